// File: rtl/sdram_slot_arbiter.sv
// Two-port slot arbiter feeding the 8-phase SDRAM controller: one access per 8-clk slot.
// Optional refresh guard: define SDRAM_ARB_REFRESH_GUARD_EN to force periodic idle slots.
module sdram_slot_arbiter #(
  parameter int unsigned AW               = 24,
  parameter int unsigned MAX_WAIT         = 4,
  parameter int unsigned REFRESH_INTERVAL = 64
) (
  input  logic          clk,
  input  logic          reset,
  output logic          sd_sync,
  output logic          sd_oe,
  output logic          sd_we,
  output logic [AW-1:0] sd_addr,
  output logic [15:0]   sd_din,
  output logic [1:0]    sd_ds,
  input  logic [15:0]   sd_dout,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [15:0]   a_wdata,
  input  logic [1:0]    a_ds,
  output logic          a_ack,
  output logic [15:0]   a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [15:0]   b_wdata,
  input  logic [1:0]    b_ds,
  output logic          b_ack,
  output logic [15:0]   b_rdata
);

  localparam int unsigned BW = $clog2(MAX_WAIT + 1);
  localparam logic [BW-1:0] BWAIT_MAX = BW'(MAX_WAIT);

  logic [2:0]    p;
  logic [2:0]    p_next;
  logic          slot_end;
  logic          gnt_a;
  logic          gnt_b;
  logic [BW-1:0] bwait;
  logic          force_idle;
  logic          win_a;
  logic          win_b;

  always_comb begin
    p_next   = p + 3'd1;
    slot_end = (p == 3'd7);
    win_b    = !force_idle && b_req && (!a_req || (bwait >= BWAIT_MAX));
    win_a    = !force_idle && a_req && !win_b;
  end

`ifdef SDRAM_ARB_REFRESH_GUARD_EN
  localparam int unsigned CW = $clog2(REFRESH_INTERVAL + 1);
  localparam logic [CW-1:0] SLOT_MAX = CW'(REFRESH_INTERVAL);

  // Run length of consecutive granted slots; hitting the limit buys one refresh slot.
  logic [CW-1:0] slot_cnt;

  assign force_idle = (slot_cnt >= SLOT_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_cnt <= '0;
    end else if (slot_end) begin
      if (win_a || win_b) begin
        slot_cnt <= slot_cnt + 1'b1;
      end else begin
        slot_cnt <= '0;
      end
    end
  end
`else
  assign force_idle = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      p       <= 3'd7;
      sd_sync <= 1'b0;
      sd_oe   <= 1'b0;
      sd_we   <= 1'b0;
      sd_addr <= '0;
      sd_din  <= '0;
      sd_ds   <= '0;
      gnt_a   <= 1'b0;
      gnt_b   <= 1'b0;
      bwait   <= '0;
      a_ack   <= 1'b0;
      b_ack   <= 1'b0;
      a_rdata <= '0;
      b_rdata <= '0;
    end else begin
      p       <= p_next;
      sd_sync <= ~p_next[2];
      a_ack   <= 1'b0;
      b_ack   <= 1'b0;
      if (slot_end) begin
        // Close out the finishing slot; controller read data is valid in phase 7.
        if (gnt_a) begin
          a_ack <= 1'b1;
          if (!sd_we) a_rdata <= sd_dout;
        end
        if (gnt_b) begin
          b_ack <= 1'b1;
          if (!sd_we) b_rdata <= sd_dout;
        end
        gnt_a <= win_a;
        gnt_b <= win_b;
        if (win_b) begin
          sd_oe   <= !b_we;
          sd_we   <= b_we;
          sd_addr <= b_addr;
          sd_din  <= b_wdata;
          sd_ds   <= b_ds;
        end else if (win_a) begin
          sd_oe   <= !a_we;
          sd_we   <= a_we;
          sd_addr <= a_addr;
          sd_din  <= a_wdata;
          sd_ds   <= a_ds;
        end else begin
          sd_oe   <= 1'b0;
          sd_we   <= 1'b0;
          sd_addr <= '0;
          sd_din  <= '0;
          sd_ds   <= '0;
        end
        // A forced refresh slot is not B's loss, so bwait holds there.
        if (win_b || !b_req) begin
          bwait <= '0;
        end else if (!force_idle && (bwait < BWAIT_MAX)) begin
          bwait <= bwait + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sdram_slot_arbiter.sv
// Directed bench for sdram_slot_arbiter; expected grant tables follow SDRAM_ARB_REFRESH_GUARD_EN.
module tb_sdram_slot_arbiter;

  localparam int unsigned AW = 24;
  localparam logic [AW-1:0] A4_ADDR = 24'h00A0A0;
  localparam logic [AW-1:0] B4_ADDR = 24'h00B0B0;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          sd_sync, sd_oe, sd_we;
  logic [AW-1:0] sd_addr;
  logic [15:0]   sd_din;
  logic [1:0]    sd_ds;
  logic [15:0]   sd_dout;
  logic          a_req = 1'b0, a_we = 1'b0;
  logic [AW-1:0] a_addr = '0;
  logic [15:0]   a_wdata = '0;
  logic [1:0]    a_ds = 2'b11;
  logic          a_ack;
  logic [15:0]   a_rdata;
  logic          b_req = 1'b0, b_we = 1'b0;
  logic [AW-1:0] b_addr = '0;
  logic [15:0]   b_wdata = '0;
  logic [1:0]    b_ds = 2'b11;
  logic          b_ack;
  logic [15:0]   b_rdata;

  logic [2:0]  tb_p;
  logic [15:0] rd_val = 16'h0000;
  int          checks = 0;
  int          failures = 0;
  logic [1:0]  exp_seq [10];
  logic [1:0]  exp_a [10];
  logic [1:0]  prev;
  logic [31:0] code;

  sdram_slot_arbiter #(
    .AW               (AW),
    .MAX_WAIT         (4),
    .REFRESH_INTERVAL (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .sd_sync (sd_sync),
    .sd_oe   (sd_oe),
    .sd_we   (sd_we),
    .sd_addr (sd_addr),
    .sd_din  (sd_din),
    .sd_ds   (sd_ds),
    .sd_dout (sd_dout),
    .a_req   (a_req),
    .a_we    (a_we),
    .a_addr  (a_addr),
    .a_wdata (a_wdata),
    .a_ds    (a_ds),
    .a_ack   (a_ack),
    .a_rdata (a_rdata),
    .b_req   (b_req),
    .b_we    (b_we),
    .b_addr  (b_addr),
    .b_wdata (b_wdata),
    .b_ds    (b_ds),
    .b_ack   (b_ack),
    .b_rdata (b_rdata)
  );

  always #5 clk = ~clk;

  // Reference phase, used to model controller read-data timing.
  always @(posedge clk) begin
    if (reset) tb_p <= 3'd7;
    else       tb_p <= tb_p + 3'd1;
  end

  assign sd_dout = (tb_p == 3'd7) ? rd_val : 16'hDEAD;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_phase(input logic [2:0] ph);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tb_p != ph && n < 16);
  endtask

  function automatic logic [31:0] slot_code();
    if (!sd_oe && !sd_we)    return 32'd0;
    if (sd_addr == A4_ADDR)  return 32'd1;
    if (sd_addr == B4_ADDR)  return 32'd2;
    return 32'd3;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef SDRAM_ARB_REFRESH_GUARD_EN
    exp_seq = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd2, 2'd1, 2'd1, 2'd1, 2'd0};
    exp_a   = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0};
`else
    exp_seq = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2};
    exp_a   = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1};
`endif
    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_sync", sd_sync, 0);
    chk("rst_oe", sd_oe, 0);
    chk("rst_we", sd_we, 0);
    chk("rst_addr", sd_addr, 0);
    chk("rst_a_ack", a_ack, 0);
    chk("rst_b_ack", b_ack, 0);
    chk("rst_a_rdata", a_rdata, 0);
    chk("rst_b_rdata", b_rdata, 0);
    reset = 1'b0;

    // Idle: sync 4 high / 4 low, no requests issued to the controller.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("idle_sync", sd_sync, (i % 8) < 4 ? 32'd1 : 32'd0);
      chk("idle_oe", sd_oe, 0);
      chk("idle_we", sd_we, 0);
      chk("idle_ack", {a_ack, b_ack}, 0);
    end

    // A read.
    rd_val = 16'hBEEF;
    a_req = 1'b1; a_we = 1'b0; a_addr = 24'h001234;
    wait_phase(3'd0);
    chk("ard_sync", sd_sync, 1);
    for (int i = 0; i < 8; i++) begin
      chk("ard_oe", sd_oe, 1);
      chk("ard_we", sd_we, 0);
      chk("ard_addr", sd_addr, 32'h001234);
      chk("ard_ack_early", a_ack, 0);
      if (i == 7) a_req = 1'b0;
      else        @(negedge clk);
    end
    @(negedge clk);
    chk("ard_ack", a_ack, 1);
    chk("ard_rdata", a_rdata, 32'hBEEF);
    chk("ard_idle_after", sd_oe, 0);
    @(negedge clk);
    chk("ard_ack_pulse", a_ack, 0);

    // B write.
    rd_val = 16'h1111;
    b_req = 1'b1; b_we = 1'b1; b_addr = 24'h00ABCD; b_wdata = 16'h55AA; b_ds = 2'b01;
    wait_phase(3'd0);
    for (int i = 0; i < 8; i++) begin
      chk("bwr_we", sd_we, 1);
      chk("bwr_oe", sd_oe, 0);
      chk("bwr_din", sd_din, 32'h55AA);
      chk("bwr_ds", sd_ds, 32'h1);
      chk("bwr_addr", sd_addr, 32'h00ABCD);
      if (i == 7) b_req = 1'b0;
      else        @(negedge clk);
    end
    @(negedge clk);
    chk("bwr_ack", b_ack, 1);
    chk("bwr_rdata", b_rdata, 0);
    chk("bwr_a_rdata", a_rdata, 32'hBEEF);
    chk("bwr_a_ack", a_ack, 0);
    b_we = 1'b0; b_ds = 2'b11;

    // Contention: A priority, B forced through after MAX_WAIT losses.
    wait_phase(3'd2);
    a_req = 1'b1; a_addr = A4_ADDR;
    b_req = 1'b1; b_addr = B4_ADDR;
    prev = 2'd0;
    for (int s = 0; s < 10; s++) begin
      wait_phase(3'd0);
      code = slot_code();
      chk("mix_grant", code, {30'd0, exp_seq[s]});
      chk("mix_a_ack", a_ack, prev == 2'd1 ? 32'd1 : 32'd0);
      chk("mix_b_ack", b_ack, prev == 2'd2 ? 32'd1 : 32'd0);
      prev = exp_seq[s];
    end
    wait_phase(3'd7);
    a_req = 1'b0; b_req = 1'b0;
    @(negedge clk);
    chk("mix_last_a_ack", a_ack, prev == 2'd1 ? 32'd1 : 32'd0);
    chk("mix_last_b_ack", b_ack, prev == 2'd2 ? 32'd1 : 32'd0);
    chk("mix_idle_after", {sd_oe, sd_we}, 0);

    // Reset in phase 3 of a granted A read abandons it.
    rd_val = 16'h4321;
    a_req = 1'b1; a_we = 1'b0; a_addr = 24'h000777;
    wait_phase(3'd0);
    chk("rmid_granted", sd_oe, 1);
    wait_phase(3'd3);
    reset = 1'b1;
    @(negedge clk);
    chk("rmid_oe", sd_oe, 0);
    chk("rmid_we", sd_we, 0);
    chk("rmid_addr", sd_addr, 0);
    chk("rmid_sync", sd_sync, 0);
    chk("rmid_ack", a_ack, 0);
    chk("rmid_rdata", a_rdata, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rmid_regrant_oe", sd_oe, 1);
    chk("rmid_regrant_addr", sd_addr, 32'h000777);
    chk("rmid_no_ack", a_ack, 0);
    wait_phase(3'd7);
    chk("rmid_no_ack_late", a_ack, 0);
    a_req = 1'b0;
    @(negedge clk);
    chk("rmid_ack", a_ack, 1);
    chk("rmid_rdata_new", a_rdata, 32'h4321);

    // A alone, continuously: idle slots only with the refresh guard.
    a_addr = A4_ADDR;
    a_req = 1'b1;
    for (int s = 0; s < 10; s++) begin
      wait_phase(3'd0);
      code = slot_code();
      chk("refr_grant", code, {30'd0, exp_a[s]});
    end
    wait_phase(3'd7);
    a_req = 1'b0;
    repeat (8) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sdram_slot_arbiter.md
Name: sdram_slot_arbiter

Overview:
- Upstream neighbour of the 8-phase SDRAM controller. Generates the controller's sync strobe.
- Arbitrates two requester ports into one SDRAM access per 8-clk slot:
  - port A: CPU/cartridge, priority;
  - port B: ROM loader / DMA.
- Holds the winning request stable for the whole slot, then captures the controller's read data and acknowledges the requester.

Parameters:
- AW, 24, word address width (matches controller address bus).
- MAX_WAIT, 4, slots port B may lose consecutively before it is forced to win.
- REFRESH_INTERVAL, 64, max slots between idle (refresh) slots; used only with the optional feature.

Ports:
- clk  in  1  SDRAM clock (8x slot rate).
- reset  in  1  synchronous, active-high.
- sd_sync  out  1  slot strobe to controller; high in phases 0-3.
- sd_oe  out  1  read request to controller.
- sd_we  out  1  write request to controller.
- sd_addr  out  AW  word address to controller.
- sd_din  out  16  write data to controller.
- sd_ds  out  2  byte strobes {upper,lower} to controller.
- sd_dout  in  16  read data from controller.
- a_req  in  1  port A request (level).
- a_we  in  1  port A write (1) / read (0).
- a_addr  in  AW  port A address.
- a_wdata  in  16  port A write data.
- a_ds  in  2  port A byte strobes.
- a_ack  out  1  one-clk completion pulse.
- a_rdata  out  16  port A read data, valid with a_ack, held until next A read ack.
- b_req, b_we, b_addr, b_wdata, b_ds, b_ack, b_rdata: same as port A, for port B.

Behaviour:
- Phase counter
  - 3-bit phase p increments every clk and wraps 7->0.
  - sd_sync is a register, 1 while p in 0..3.
  - The rising edge of sd_sync marks the slot start.
- Slot decision
  - Made on the clk edge where p==7 (p becomes 0).
  - Grant rules:
    - B is granted if b_req and (!a_req or bwait>=MAX_WAIT).
    - Otherwise A is granted if a_req.
    - Otherwise idle.
  - sd_oe/sd_we/sd_addr/sd_din/sd_ds are registered at that edge and held unchanged for all 8 phases of the slot.
  - Idle slot: sd_oe=sd_we=0, so the controller performs auto-refresh.
- bwait counter
  - Increments (saturating at MAX_WAIT) on each decision where b_req=1 and B is not granted.
  - Cleared when B is granted or b_req=0.
- Completion
  - On the p==7 edge ending a granted slot: assert that port's ack for exactly 1 clk.
  - For reads, also load its rdata from sd_dout (controller data is valid during p==7).
  - Writes ack at the same point; rdata is unchanged.
  - The next slot's decision happens on the same edge, so back-to-back slots are possible.
- Requester rules
  - req and its qualifiers must stay stable until ack.
  - A req still high in the cycle after ack is a new request. It is eligible from the next decision, at the earliest 8 clks later.
  - A req dropped before grant is simply not served; no ack.
  - A req dropped after grant is still completed and acked.
- Simultaneous a_req/b_req with bwait<MAX_WAIT: A wins.
- Reset
  - Values: p=7, so the first decision comes on the first edge after reset deasserts. sd_sync=0, all sd_* request outputs 0, acks 0, rdata 0, bwait 0, in-flight grant cleared.
  - Reset mid-slot abandons the access; no ack is ever issued for it.
- Throughput: 1 access per 8 clks. Read latency from grant edge to ack is 8 clks.

Optional Feature:
- Macro SDRAM_ARB_REFRESH_GUARD_EN.
- Defined:
  - A slot counter counts consecutive non-idle slots.
  - When it reaches REFRESH_INTERVAL, the next decision is forced idle regardless of requests: no grant, bwait does not increment.
  - The counter clears on any idle slot and on reset.
- Undefined: no counter. Idle slots occur only when no port requests, so refresh can be starved by continuous traffic.

Test Plan:
- Reset release, no requests -> sd_sync toggles 4 high/4 low continuously; sd_oe=sd_we=0 every slot; no acks.
- A read, a_addr=0x001234, sd_dout model returns 0xBEEF in p==7 -> sd_oe=1, sd_addr=0x001234 held 8 clks; a_ack 1-clk pulse 8 clks after grant; a_rdata=0xBEEF.
- B write, b_wdata=0x55AA, b_ds=2'b01 -> sd_we=1, sd_din=0x55AA, sd_ds=01 for full slot; b_ack after 8 clks; b_rdata unchanged.
- a_req and b_req held continuously, MAX_WAIT=4 -> grant sequence A,A,A,A,B repeating; no slot idle.
- Reset asserted in phase 3 of a granted A read -> no a_ack ever; all sd_* outputs 0; first post-reset decision serves the still-pending a_req.
- With SDRAM_ARB_REFRESH_GUARD_EN and REFRESH_INTERVAL=4, a_req held high -> every 5th slot idle (sd_oe=sd_we=0); without the macro, every slot is granted.
